// File: rtl/hamming_scrub_scheduler_pkg.sv
// Shared types and constants for the Hamming counter scrub scheduler.
// The state encoding is visible on state_o, so it is fixed here.
package hamming_sched_pkg;

   localparam int ERR_CNT_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_HOLD  = 3'd2,
      S_CHECK = 3'd3,
      S_FIX   = 3'd4,
      S_DONE  = 3'd5
   } sched_state_t;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_HOLD  = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_FIX   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/hamming_scrub_scheduler_if.sv
// Link between the scrub scheduler and the Hamming-protected counter.
// The scheduler owns enable; the counter reports parity capture and errors.
interface hamming_scrub_scheduler_if;

   logic cnt_enable;
   logic cnt_busy;
   logic cnt_error;

   modport master (output cnt_enable, input cnt_busy, input cnt_error);
   modport slave  (input cnt_enable, output cnt_busy, output cnt_error);

endinterface

// File: rtl/hamming_scrub_scheduler_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/hamming_scrub_scheduler.sv
// Scrub sequencer: stops the Hamming counter periodically, waits for parity
// capture, checks the syndrome, allows correction write-back, then resumes.
module hamming_scrub_scheduler
   import hamming_sched_pkg::*;
#(
   parameter int SCRUB_PERIOD = 1024,
   parameter int HOLD_TIMEOUT = 8,
   parameter int FIX_CYCLES   = 2,
   parameter int ERR_CNT_W    = ERR_CNT_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      run_req,
   input  logic                      scrub_req,
   input  logic                      stat_clear,
   hamming_scrub_scheduler_if.master cnt,
   output logic [2:0]                state_o,
   output logic                      scrub_done,
   output logic [ERR_CNT_W-1:0]      err_count,
   output logic [ERR_CNT_W-1:0]      scrub_count,
   output logic                      timeout_flag
);

   localparam int PER_W = $clog2(SCRUB_PERIOD);
   localparam int FIX_W = (FIX_CYCLES > 1) ? $clog2(FIX_CYCLES) : 1;

   localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SCRUB_PERIOD - 1);
   localparam logic [7:0]       HOLD_LAST = 8'(HOLD_TIMEOUT - 1);
   localparam logic [FIX_W-1:0] FIX_LAST  = FIX_W'(FIX_CYCLES - 1);

   sched_state_t     state;
   logic [PER_W-1:0] period_cnt;
   logic [7:0]       wait_cnt;
   logic [FIX_W-1:0] fix_cnt;
   logic             inc_err;
   logic             inc_scrub;
   logic             hold_expire;

   // Counter updates land on the same edge as the matching state change.
   assign inc_err     = (state == S_CHECK) && cnt.cnt_error;
   assign inc_scrub   = ((state == S_CHECK) && !cnt.cnt_error) ||
                        ((state == S_FIX) && (fix_cnt == FIX_LAST));
   assign hold_expire = (state == S_HOLD) && !cnt.cnt_busy && (wait_cnt == HOLD_LAST);

   assign cnt.cnt_enable = (state == S_RUN);
   assign state_o        = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         scrub_done   <= 1'b0;
         timeout_flag <= 1'b0;
         period_cnt   <= '0;
         wait_cnt     <= '0;
         fix_cnt      <= '0;
      end else begin
         scrub_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run_req) state <= S_RUN;
            end
            S_RUN: begin
               if ((period_cnt == PER_LAST) || scrub_req || !run_req) begin
                  state      <= S_HOLD;
                  period_cnt <= '0;
                  wait_cnt   <= '0;
               end else begin
                  period_cnt <= period_cnt + PER_W'(1);
               end
            end
            S_HOLD: begin
               // busy is honoured even on the last allowed HOLD cycle
               if (cnt.cnt_busy) begin
                  state <= S_CHECK;
               end else if (wait_cnt == HOLD_LAST) begin
                  state      <= S_DONE;
                  scrub_done <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_CHECK: begin
               if (cnt.cnt_error) begin
                  state   <= S_FIX;
                  fix_cnt <= '0;
               end else begin
                  state      <= S_DONE;
                  scrub_done <= 1'b1;
               end
            end
            S_FIX: begin
               if (fix_cnt == FIX_LAST) begin
                  state      <= S_DONE;
                  scrub_done <= 1'b1;
               end else begin
                  fix_cnt <= fix_cnt + FIX_W'(1);
               end
            end
            S_DONE: begin
               state <= run_req ? S_RUN : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (stat_clear) begin
            timeout_flag <= 1'b0;
         end else if (hold_expire) begin
            timeout_flag <= 1'b1;
         end
      end
   end

   sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stat_clear),
      .inc     (inc_err),
      .q       (err_count)
   );

   sat_counter #(.W(ERR_CNT_W)) u_scrub_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (stat_clear),
      .inc     (inc_scrub),
      .q       (scrub_count)
   );

endmodule
